// File: rtl/xbar_out_arbiter.sv
// Round-robin NUM_IN:1 output arbiter with a registered valid/ready output stage.
// Define XBAR_PKT_LOCK_EN to hold the grant for a whole packet (in_last-delimited).
module xbar_out_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 64,
  localparam int PTR_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN-1:0]            in_last,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [NUM_IN-1:0]            grant
);

  localparam logic [PTR_W:0] NUM_IN_W = (PTR_W+1)'(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [NUM_IN-1:0]       lock_grant_q, lock_grant_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;

  logic [DATA_WIDTH-1:0]   ch_data [NUM_IN];
  logic [NUM_IN-1:0]       rr_grant;
  logic                    found;
  logic [PTR_W:0]          idx_sum, idx_wrap;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W:0]          ptr_inc;
  logic [PTR_W-1:0]        ptr_wrap;
  logic                    stage_free;
  logic                    accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping explicitly so non-power-of-2 NUM_IN works.
  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    idx_sum  = '0;
    idx_wrap = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx_sum  = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      idx_wrap = (idx_sum >= NUM_IN_W) ? (idx_sum - NUM_IN_W) : idx_sum;
      if (!found && in_valid[idx_wrap[PTR_W-1:0]]) begin
        rr_grant[idx_wrap[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign grant      = !rst_n ? '0 : ((state_q == LOCKED) ? lock_grant_q : rr_grant);
  assign stage_free = !out_valid_q || out_ready;
  assign in_ready   = grant & {NUM_IN{stage_free}};
  assign accept     = |(in_valid & in_ready);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign ptr_inc  = {1'b0, gnt_idx} + (PTR_W+1)'(1);
  assign ptr_wrap = (ptr_inc >= NUM_IN_W) ? '0 : ptr_inc[PTR_W-1:0];

  always_comb begin
    state_d      = state_q;
    lock_grant_d = lock_grant_q;
    rr_ptr_d     = rr_ptr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;

    if (accept) begin
      out_data_d  = ch_data[gnt_idx];
      out_last_d  = in_last[gnt_idx];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

`ifdef XBAR_PKT_LOCK_EN
    if (accept) begin
      if (in_last[gnt_idx]) begin
        rr_ptr_d     = ptr_wrap;
        state_d      = IDLE;
        lock_grant_d = '0;
      end else if (state_q == IDLE) begin
        state_d      = LOCKED;
        lock_grant_d = grant;
      end
    end
`else
    // Without locking every beat is its own arbitration round.
    if (accept) rr_ptr_d = ptr_wrap;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lock_grant_q <= '0;
      rr_ptr_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_grant_q <= lock_grant_d;
      rr_ptr_q     <= rr_ptr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
